// File: rtl/dmem_ctrl.sv
// Data-memory controller between the core MEM stage and a word-wide SRAM
// with byte enables. Steers byte/half/word accesses onto SRAM lanes, inserts
// WAIT_CYCLES wait states, interlocks the core through ackd_n, and flags
// misaligned accesses in sticky error state.
module dmem_ctrl #(
    parameter int ADDR_W      = 14,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       dad,
    input  logic [31:0]       ddt_w,
    output logic [31:0]       ddt_r,
    input  logic              mreq,
    input  logic              write,
    input  logic [1:0]        size,
    output logic              ackd_n,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              misalign_err,
    output logic [31:0]       err_addr
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    state_t            state_q;
    logic [ADDR_W+1:0] addr_q;
    logic [1:0]        size_q;
    logic              write_q;
    logic [31:0]       wdata_q;
    logic [3:0]        cnt_q;
    logic              mis_q;
    logic              err_q;
    logic [31:0]       err_addr_q;
    logic              mis_d;

    // Alignment check on the incoming request; size 11 is reserved and always rejected.
    always_comb begin
        mis_d = 1'b0;
        case (size)
            2'b00:   mis_d = (dad[1:0] != 2'b00);
            2'b01:   mis_d = dad[0];
            2'b10:   mis_d = 1'b0;
            default: mis_d = 1'b1;
        endcase
    end

    // Request FSM: capture, count wait states, one SRAM cycle, one completion cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            size_q     <= 2'b00;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            cnt_q      <= 4'd0;
            mis_q      <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mreq) begin
                        addr_q  <= dad[ADDR_W+1:0];
                        size_q  <= size;
                        write_q <= write;
                        wdata_q <= ddt_w;
                        mis_q   <= mis_d;
                        if (mis_d) begin
                            // err_addr keeps the first offender until reset
                            if (!err_q) err_addr_q <= dad;
                            err_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else if (WAIT_CYCLES > 0) begin
                            cnt_q   <= WAIT_INIT;
                            state_q <= S_WAIT;
                        end else begin
                            state_q <= S_ACCESS;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) state_q <= S_ACCESS;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                S_ACCESS: state_q <= S_DONE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    // SRAM drive decodes only from state and captured request, so it is clean in ACCESS.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_wdata = '0;
        if (state_q == S_ACCESS) begin
            mem_en = 1'b1;
            if (write_q) begin
                case (size_q)
                    2'b10: begin
                        mem_we    = 4'b0001 << addr_q[1:0];
                        mem_wdata = {4{wdata_q[7:0]}};
                    end
                    2'b01: begin
                        mem_we    = addr_q[1] ? 4'b1100 : 4'b0011;
                        mem_wdata = {2{wdata_q[15:0]}};
                    end
                    default: begin
                        mem_we    = 4'b1111;
                        mem_wdata = wdata_q;
                    end
                endcase
            end
        end
    end

    // Load return: SRAM data arrives in DONE; right-align and zero-fill above the access size.
    always_comb begin
        ddt_r = '0;
        if (state_q == S_DONE && !write_q && !mis_q) begin
            case (size_q)
                2'b10:   ddt_r = {24'b0, 8'(mem_rdata >> {addr_q[1:0], 3'b000})};
                2'b01:   ddt_r = {16'b0, 16'(mem_rdata >> {addr_q[1], 4'b0000})};
                default: ddt_r = mem_rdata;
            endcase
        end
    end

    assign mem_addr     = addr_q[ADDR_W+1:2];
    assign ackd_n       = mreq & (state_q != S_DONE);
    assign misalign_err = err_q;
    assign err_addr     = err_addr_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: three instances (WAIT_CYCLES 1, 0, 3), each with its
// own SRAM and a transaction-level reference model (byte-array memory plus
// latency arithmetic) checked every cycle, plus directed literal checks.
module tb_dmem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL inst%0d %s: got %h expected %h", id, nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : inst
        localparam int W = (g == 0) ? 1 : ((g == 1) ? 0 : 3);

        logic        rst_n = 1'b0;
        logic [31:0] dad = '0, ddt_w = '0, ddt_r, mem_wdata, err_addr;
        logic [31:0] mem_rdata = '0;
        logic        mreq = 1'b0, write = 1'b0;
        logic [1:0]  size = 2'b00;
        logic        ackd_n, mem_en, misalign_err;
        logic [3:0]  mem_we;
        logic [13:0] mem_addr;
        logic        fin = 1'b0;

        dmem_ctrl #(.ADDR_W(14), .WAIT_CYCLES(W)) dut (
            .clk(clk), .rst_n(rst_n), .dad(dad), .ddt_w(ddt_w), .ddt_r(ddt_r),
            .mreq(mreq), .write(write), .size(size), .ackd_n(ackd_n),
            .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
            .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
            .misalign_err(misalign_err), .err_addr(err_addr)
        );

        // SRAM: byte-enabled write, read data the cycle after the enable
        logic [31:0] sram [0:16383];
        initial for (int i = 0; i < 16384; i++) sram[i] = '0;
        always @(posedge clk) begin
            if (mem_en) begin
                for (int i = 0; i < 4; i++)
                    if (mem_we[i]) sram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
                if (mem_we == 4'b0000) mem_rdata <= sram[mem_addr];
            end
        end

        // ---- reference model: byte memory + per-transaction cycle index ----
        logic [7:0]  bm [0:65535];
        initial for (int i = 0; i < 65536; i++) bm[i] = 8'h00;
        int          ph = -1;      // -1 idle, else cycles since acceptance
        logic [31:0] ra = '0, rd = '0, m_eaddr = '0;
        logic [1:0]  rs = 2'b00;
        logic        rw = 1'b0, rmis = 1'b0, m_err = 1'b0;

        function automatic int nbytes(input logic [1:0] s);
            return (s == 2'b00) ? 4 : ((s == 2'b01) ? 2 : 1);
        endfunction
        function automatic logic is_mis(input logic [31:0] a, input logic [1:0] s);
            return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b00 && a[1:0] != 2'b00);
        endfunction
        function automatic int last_ph();
            return rmis ? 1 : W + 2;
        endfunction
        function automatic logic in_access();
            return ph > 0 && !rmis && ph == W + 1;
        endfunction
        function automatic logic in_done();
            return ph > 0 && ph == last_ph();
        endfunction
        function automatic logic [31:0] load_val();
            logic [31:0] v = '0;
            for (int k = 0; k < nbytes(rs); k++) v[8*k +: 8] = bm[16'(ra + k)];
            return v;
        endfunction
        function automatic logic [3:0] exp_we();
            logic [3:0] m = '0;
            for (int k = 0; k < nbytes(rs); k++) m[(int'(ra[1:0]) + k) % 4] = 1'b1;
            return m;
        endfunction
        function automatic logic [31:0] exp_wd();
            return (rs == 2'b10) ? {4{rd[7:0]}} : ((rs == 2'b01) ? {2{rd[15:0]}} : rd);
        endfunction

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ph = -1; m_err = 1'b0; m_eaddr = '0;
            end else if (ph < 0) begin
                if (mreq) begin
                    ra = dad; rd = ddt_w; rw = write; rs = size;
                    rmis = is_mis(dad, size);
                    if (rmis) begin
                        if (!m_err) m_eaddr = dad;
                        m_err = 1'b1;
                    end
                    ph = 1;
                end
            end else begin
                if (in_access() && rw)
                    for (int k = 0; k < nbytes(rs); k++) bm[16'(ra + k)] = rd[8*k +: 8];
                ph = in_done() ? -1 : ph + 1;
            end
        end

        // Every-cycle comparison against the model, away from the active edge
        always @(negedge clk) begin
            chk(g, "ackd_n", {31'b0, ackd_n}, {31'b0, mreq & ~in_done()});
            chk(g, "mem_en", {31'b0, mem_en}, {31'b0, in_access()});
            chk(g, "mem_we", {28'b0, mem_we}, {28'b0, (in_access() && rw) ? exp_we() : 4'b0000});
            if (in_access()) chk(g, "mem_addr", {18'b0, mem_addr}, {18'b0, ra[15:2]});
            if (in_access() && rw) chk(g, "mem_wdata", mem_wdata, exp_wd());
            chk(g, "ddt_r", ddt_r, (in_done() && !rw && !rmis) ? load_val() : 32'h0);
            chk(g, "misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
            chk(g, "err_addr", err_addr, m_eaddr);
        end

        // ---- stimulus ----
        logic [3:0]  s_we;
        logic [13:0] s_addr;
        logic [31:0] s_wd, s_rd;
        logic        s_en;
        int          s_lat;

        // Called at posedge+1 of an IDLE cycle; returns at posedge+1 after DONE
        // with mreq still high so a following call is back-to-back.
        task automatic req(input logic [31:0] a, input logic wr, input logic [1:0] s, input logic [31:0] d);
            dad = a; write = wr; size = s; ddt_w = d; mreq = 1'b1;
            s_lat = 0; s_en = 1'b0; s_we = '0; s_addr = '0; s_wd = '0;
            #1;
            while (ackd_n === 1'b1 && s_lat < 40) begin
                if (mem_en) begin
                    s_en = 1'b1; s_we = mem_we; s_addr = mem_addr; s_wd = mem_wdata;
                end
                @(posedge clk); #2;
                s_lat++;
            end
            if (s_lat >= 40) chk(g, "ack_timeout", 32'(s_lat), 32'd0);
            s_rd = ddt_r;
            @(posedge clk); #1;
        endtask

        task automatic idle(input int n);
            mreq = 1'b0;
            repeat (n) @(posedge clk);
            #1;
        endtask

        initial begin
            logic [31:0] a, d;
            logic [1:0]  s;
            repeat (2) @(posedge clk);
            #1;
            chk(g, "rst_mem_en", {31'b0, mem_en}, 32'd0);
            chk(g, "rst_mem_we", {28'b0, mem_we}, 32'd0);
            chk(g, "rst_mem_addr", {18'b0, mem_addr}, 32'd0);
            chk(g, "rst_mem_wdata", mem_wdata, 32'd0);
            chk(g, "rst_ddt_r", ddt_r, 32'd0);
            chk(g, "rst_ackd_n", {31'b0, ackd_n}, 32'd0);
            chk(g, "rst_err", {31'b0, misalign_err}, 32'd0);
            chk(g, "rst_err_addr", err_addr, 32'd0);
            rst_n = 1'b1;
            idle(1);

            req(32'h100, 1'b1, 2'b00, 32'hDEADBEEF);
            chk(g, "sw_lat", 32'(s_lat), 32'(W + 2));
            chk(g, "sw_we", {28'b0, s_we}, 32'hF);
            chk(g, "sw_addr", {18'b0, s_addr}, 32'h40);
            chk(g, "sw_wd", s_wd, 32'hDEADBEEF);
            req(32'h100, 1'b0, 2'b00, 32'h0);
            chk(g, "lw_data", s_rd, 32'hDEADBEEF);

            for (int i = 0; i < 4; i++) begin
                req(32'h200 + 32'(i), 1'b1, 2'b10, 32'h11 * 32'(i + 1));
                chk(g, "sb_we", {28'b0, s_we}, 32'(1 << i));
            end
            req(32'h200, 1'b0, 2'b00, 32'h0);
            chk(g, "lw_bytes", s_rd, 32'h44332211);
            req(32'h202, 1'b0, 2'b10, 32'h0);
            chk(g, "lb_202", s_rd, 32'h00000033);

            req(32'h306, 1'b1, 2'b01, 32'h1234BEEF);
            chk(g, "sh_we", {28'b0, s_we}, 32'hC);
            chk(g, "sh_wd", s_wd, 32'hBEEFBEEF);
            req(32'h306, 1'b0, 2'b01, 32'h0);
            chk(g, "lh_306", s_rd, 32'h0000BEEF);

            idle(1);
            req(32'h101, 1'b0, 2'b00, 32'h0);
            chk(g, "mis_lat", 32'(s_lat), 32'd1);
            chk(g, "mis_no_en", {31'b0, s_en}, 32'd0);
            chk(g, "mis_ddt_r", s_rd, 32'd0);
            chk(g, "mis_flag", {31'b0, misalign_err}, 32'd1);
            chk(g, "mis_addr", err_addr, 32'h101);
            req(32'h203, 1'b0, 2'b01, 32'h0);
            chk(g, "mis2_addr", err_addr, 32'h101);

            // mreq held past DONE: the same store is issued again, identically
            req(32'h400, 1'b1, 2'b00, 32'hCAFEF00D);
            req(32'h400, 1'b1, 2'b00, 32'hCAFEF00D);
            chk(g, "reissue_lat", 32'(s_lat), 32'(W + 2));
            chk(g, "reissue_we", {28'b0, s_we}, 32'hF);
            chk(g, "reissue_wd", s_wd, 32'hCAFEF00D);
            idle(1);

            repeat (150) begin
                a = $urandom;
                a[15:0] = 16'h0200 + 16'($urandom_range(0, 63));
                s = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 3) != 0) begin
                    if (s == 2'b00) a[1:0] = 2'b00;
                    if (s == 2'b01) a[0] = 1'b0;
                end
                d = $urandom;
                if ($urandom_range(0, 7) == 0) begin
                    // request withdrawn after one cycle; captured access still completes
                    dad = a; write = 1'($urandom); size = s; ddt_w = d; mreq = 1'b1;
                    @(posedge clk); #1;
                    mreq = 1'b0;
                    repeat (W + 4) @(posedge clk);
                    #1;
                end else begin
                    req(a, 1'($urandom), s, d);
                    chk(g, "rnd_lat", 32'(s_lat), is_mis(a, s) ? 32'd1 : 32'(W + 2));
                    idle($urandom_range(0, 2));
                end
            end

            // reset mid-store: no write may land, outputs return to reset values
            idle(1);
            dad = 32'h500; write = 1'b1; size = 2'b00; ddt_w = 32'h12345678; mreq = 1'b1;
            @(posedge clk); #1;
            rst_n = 1'b0;
            #1;
            chk(g, "arst_mem_en", {31'b0, mem_en}, 32'd0);
            chk(g, "arst_mem_we", {28'b0, mem_we}, 32'd0);
            chk(g, "arst_mem_addr", {18'b0, mem_addr}, 32'd0);
            chk(g, "arst_mem_wdata", mem_wdata, 32'd0);
            chk(g, "arst_err", {31'b0, misalign_err}, 32'd0);
            chk(g, "arst_err_addr", err_addr, 32'd0);
            mreq = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            idle(1);
            req(32'h500, 1'b0, 2'b00, 32'h0);
            chk(g, "post_rst_data", s_rd, 32'h0);
            chk(g, "post_rst_lat", 32'(s_lat), 32'(W + 2));
            idle(2);
            fin = 1'b1;
        end
    end

    initial begin
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk);
            if (inst[0].fin && inst[1].fin && inst[2].fin) break;
        end
        chk(-1, "all_done", {29'b0, inst[2].fin, inst[1].fin, inst[0].fin}, 32'h7);
        #20;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller sitting directly downstream of the core's MEM stage, between the core data bus (address, write data, read data, request, write, size, acknowledge) and a word-wide synchronous SRAM with byte enables. It converts byte/half/word requests into word accesses with lane steering, inserts a configurable number of wait states, and drives the core's active-low ready (ACKD_n) so the pipeline interlocks until data is valid. It also detects misaligned accesses and records them in sticky error state.

## Interface
- ADDR_W, 14: SRAM word-address width; byte address bits [ADDR_W+1:2] select the word, upper bits ignored (aliasing).
- WAIT_CYCLES, 1: extra wait states before the SRAM access, 0..15.

- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- dad  in  32  core byte address (DAD).
- ddt_w  in  32  core store data, right-aligned (value of rs2).
- ddt_r  out  32  load data to core, right-aligned, zero-filled above access size.
- mreq  in  1  core memory request (MREQ).
- write  in  1  1 = store, 0 = load (WRITE).
- size  in  2  00 word, 01 halfword, 10 byte, 11 reserved.
- ackd_n  out  1  0 = ready/complete, 1 = busy (ACKD_n).
- mem_en  out  1  SRAM enable.
- mem_we  out  4  SRAM byte write enables, bit i = lane i (bits 8i+7:8i).
- mem_addr  out  ADDR_W  SRAM word address.
- mem_wdata  out  32  SRAM write data.
- mem_rdata  in  32  SRAM read data, valid the cycle after mem_en with mem_we=0.
- misalign_err  out  1  sticky misalignment flag.
- err_addr  out  32  byte address of first misaligned access.

## Operation
- States: IDLE, WAIT, ACCESS, DONE. Registers: captured addr, size, write, wdata; 4-bit wait counter.
- ackd_n = mreq & (state != DONE). With mreq=0 ackd_n=0 in every state.
- IDLE: on mreq=1 capture request. Misaligned (size=01 and addr[0]=1; size=00 and addr[1:0]!=0; size=11) -> DONE, no SRAM access, set misalign_err and, if previously clear, load err_addr. Otherwise -> WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0, else -> ACCESS.
- WAIT: counter decrements; at 0 -> ACCESS.
- ACCESS: mem_en=1, mem_addr=captured addr[ADDR_W+1:2]; store: mem_we and mem_wdata per steering; load: mem_we=0. -> DONE.
- DONE: ackd_n=0. Load: ddt_r = steered mem_rdata; misaligned load: ddt_r=0. -> IDLE unconditionally.
- Store steering: byte: wdata={4{ddt_w[7:0]}}, we=0001<<addr[1:0]; half: wdata={2{ddt_w[15:0]}}, we=addr[1]?1100:0011; word: wdata=ddt_w, we=1111.
- Load steering: byte: (mem_rdata>>8*addr[1:0])&FF; half: (mem_rdata>>16*addr[1])&FFFF; word: mem_rdata. Sign extension is done by the core.
- mem_en, mem_we, mem_addr, mem_wdata decode from state and captured registers only; zero outside ACCESS (mem_addr/wdata may hold).
- mreq dropping mid-transaction: captured access still completes; no abort.
- If the core stays interlocked for another reason after DONE, mreq remains high and IDLE re-issues the same access; stores are idempotent, so this is accepted.
- ddt_r outside DONE: 0.

## Timing
- Reset: state IDLE, counter 0, captured regs 0, mem_en=0, mem_we=0000, mem_addr=0, mem_wdata=0, ddt_r=0, misalign_err=0, err_addr=0; ackd_n=0 while mreq=0.
- Aligned access: ackd_n=1 for WAIT_CYCLES+2 cycles (IDLE, WAIT×N, ACCESS), then 0 in DONE; total WAIT_CYCLES+3 cycles from mreq rise to pipeline advance.
- Misaligned: ackd_n=1 for 1 cycle, DONE next cycle.
- Back-to-back requests: a new request is accepted in the IDLE cycle after DONE; no dead cycle beyond that.
- Reset asserted mid-access: state IDLE and mem_en=0 immediately (asynchronous); no partial write after reset.
- misalign_err clears only on reset; err_addr holds first error.

## Test plan
- WAIT_CYCLES=1: store word 0xDEADBEEF @0x100 -> ackd_n high 3 cycles, mem_we=1111, mem_addr=0x40; load word @0x100 -> ddt_r=0xDEADBEEF in DONE.
- Byte stores 0x11,0x22,0x33,0x44 @0x200..0x203 -> mem_we 0001,0010,0100,1000; load word @0x200 -> 0x44332211; load byte @0x202 -> 0x00000033.
- Halfword store 0xBEEF @0x306 -> mem_we=1100, mem_wdata=0xBEEFBEEF; load half @0x306 -> 0x0000BEEF.
- Load word @0x101 -> no mem_en, ackd_n high 1 cycle, ddt_r=0, misalign_err=1, err_addr=0x101; later half @0x203 leaves err_addr=0x101.
- WAIT_CYCLES=0 and 3: measure ackd_n-high duration = 2 and 5 cycles; mreq held through extra cycle re-issues identical store.
- Assert rst_n low during WAIT of a store -> mem_we never asserted, all outputs at reset values, next request completes normally.
